// File: rtl/udlx_trace_pkg.sv
// Shared types for the UDLX bus-trace unit: capture modes, FSM states, entry layout.
package udlx_trace_pkg;

    typedef enum logic [1:0] {
        M_STOP_FULL = 2'd0,
        M_WRAP      = 2'd1,
        M_TRIGGER   = 2'd2
    } mode_e;

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_ARMED   = 2'd1,
        S_CAPTURE = 2'd2,
        S_DONE    = 2'd3
    } state_e;

    localparam int TS_W_DEF   = 16;
    localparam int CH_W_DEF   = 2;
    localparam int ADDR_W_DEF = 20;
    localparam int DATA_W_DEF = 32;

    // Entry layout at the default widths; rd_data packs MSB first in this order.
    typedef struct packed {
        logic [TS_W_DEF-1:0]   ts;
        logic [CH_W_DEF-1:0]   ch;
        logic [ADDR_W_DEF-1:0] addr;
        logic [DATA_W_DEF-1:0] data;
    } trace_entry_t;

    localparam logic [15:0] DROP_SAT = 16'hFFFF;

    // Encoding 3 is reserved and behaves as STOP_FULL.
    function automatic mode_e decode_mode(input logic [1:0] m);
        case (m)
            2'd1:    decode_mode = M_WRAP;
            2'd2:    decode_mode = M_TRIGGER;
            default: decode_mode = M_STOP_FULL;
        endcase
    endfunction

endpackage

// File: rtl/udlx_trace_fifo.sv
// Circular trace store: push/pop with optional overwrite-oldest when full.
module udlx_trace_fifo #(
    parameter int DEPTH = 64,
    parameter int W     = 70,
    parameter int CNT_W = $clog2(DEPTH + 1)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             clear,
    input  logic             push,
    input  logic             pop,
    input  logic             wrap_overwrite,
    input  logic [W-1:0]     wr_data,
    output logic [CNT_W-1:0] count,
    output logic             full,
    output logic [W-1:0]     head
);
    localparam int PTR_W = $clog2(DEPTH);

    logic [W-1:0]     mem [DEPTH];
    logic [PTR_W-1:0] rd_ptr;
    logic [PTR_W-1:0] wr_ptr;
    logic             pop_eff;
    logic             accept;
    logic             overwrite;

    assign full = (count == CNT_W'(DEPTH));
    assign head = mem[rd_ptr];

    always_comb begin
        pop_eff   = pop && (count != '0);
        accept    = push && (!full || wrap_overwrite);
        overwrite = push && full && wrap_overwrite;
    end

    // When full the tail slot is the head slot, so an overwrite advances the head exactly once
    // whether or not a pop happens in the same cycle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else if (clear) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else begin
            if (accept)
                wr_ptr <= wr_ptr + PTR_W'(1);
            if (pop_eff || overwrite)
                rd_ptr <= rd_ptr + PTR_W'(1);
            if (!overwrite) begin
                if (accept && !pop_eff)
                    count <= count + CNT_W'(1);
                else if (!accept && pop_eff)
                    count <= count - CNT_W'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (accept && !clear)
            mem[wr_ptr] <= wr_data;
    end

endmodule

// File: rtl/udlx_trace_buffer.sv
// UDLX multi-channel bus-trace capture: arbitration, timestamping, trigger FSM and
// valid/ready readout of a circular buffer.
module udlx_trace_buffer
    import udlx_trace_pkg::*;
#(
    parameter int N_CH       = 3,
    parameter int ADDR_WIDTH = 20,
    parameter int DATA_WIDTH = 32,
    parameter int DEPTH      = 64,
    parameter int TS_WIDTH   = 16,
    parameter int CH_W       = (N_CH > 1) ? $clog2(N_CH) : 1,
    parameter int CNT_W      = $clog2(DEPTH + 1),
    parameter int E_W        = TS_WIDTH + CH_W + ADDR_WIDTH + DATA_WIDTH
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic [N_CH-1:0]            ch_valid,
    input  logic [N_CH*ADDR_WIDTH-1:0] ch_addr,
    input  logic [N_CH*DATA_WIDTH-1:0] ch_data,
    input  logic [1:0]                 mode,
    input  logic                       start,
    input  logic                       stop,
    input  logic                       clear,
    input  logic [CH_W-1:0]            trig_ch,
    input  logic [ADDR_WIDTH-1:0]      trig_addr,
    input  logic [CNT_W-1:0]           post_cnt,
    output logic                       rd_valid,
    input  logic                       rd_ready,
    output logic [E_W-1:0]             rd_data,
    output logic [CNT_W-1:0]           count,
    output logic                       full,
    output logic                       overflow,
    output logic [15:0]                drop_cnt,
    output logic [1:0]                 state_o
);
    localparam int NV_W = $clog2(N_CH + 1);

    state_e              state_q, state_d;
    mode_e               mode_q, mode_d;
    logic [CNT_W-1:0]    post_q, post_d;
    logic [TS_WIDTH-1:0] ts_q;
    logic [15:0]         drop_q;
    logic                ovf_q;

    logic                  win_found;
    logic [CH_W-1:0]       win_idx;
    logic [NV_W-1:0]       n_valid;
    logic                  trig_hit;
    logic [CH_W-1:0]       sel_idx;
    logic [ADDR_WIDTH-1:0] sel_addr;
    logic [DATA_WIDTH-1:0] sel_data;

    logic             post_done;
    logic             cap_cycle;
    logic             push;
    logic             wrap_mode;
    logic             pop_eff;
    logic             full_drop;
    logic             lost_overwrite;
    logic [NV_W:0]    drop_inc;
    logic [16:0]      drop_sum;
    logic [CNT_W-1:0] cnt_after;
    logic [E_W-1:0]   head;

    // Lowest asserted channel wins; trigger match is evaluated on the selected trigger channel.
    always_comb begin
        win_found = 1'b0;
        win_idx   = '0;
        n_valid   = '0;
        trig_hit  = 1'b0;
        for (int unsigned i = 0; i < N_CH; i++) begin
            if (ch_valid[i]) begin
                n_valid = n_valid + NV_W'(1);
                if (!win_found) begin
                    win_found = 1'b1;
                    win_idx   = CH_W'(i);
                end
            end
            if (CH_W'(i) == trig_ch && ch_valid[i] &&
                ch_addr[i*ADDR_WIDTH +: ADDR_WIDTH] == trig_addr)
                trig_hit = 1'b1;
        end
    end

    // On the trigger cycle the trigger channel's transaction is the one recorded.
    always_comb begin
        sel_idx  = (state_q == S_ARMED) ? trig_ch : win_idx;
        sel_addr = '0;
        sel_data = '0;
        for (int unsigned i = 0; i < N_CH; i++) begin
            if (CH_W'(i) == sel_idx) begin
                sel_addr = ch_addr[i*ADDR_WIDTH +: ADDR_WIDTH];
                sel_data = ch_data[i*DATA_WIDTH +: DATA_WIDTH];
            end
        end
    end

    always_comb begin
        wrap_mode      = (mode_q == M_WRAP);
        post_done      = (mode_q == M_TRIGGER) && (post_q == '0);
        cap_cycle      = !clear && (((state_q == S_CAPTURE) && !post_done) ||
                                    ((state_q == S_ARMED) && trig_hit));
        push           = cap_cycle && win_found;
        pop_eff        = rd_ready && rd_valid && !clear;
        full_drop      = push && full && !wrap_mode;
        lost_overwrite = push && full && wrap_mode && !pop_eff;
        drop_inc       = (NV_W+1)'(push ? (n_valid - NV_W'(1)) : '0) + (NV_W+1)'(full_drop);
        drop_sum       = {1'b0, drop_q} + 17'(drop_inc);
        cnt_after      = count + CNT_W'(push && !full) - CNT_W'(pop_eff);
    end

    always_comb begin
        state_d = state_q;
        mode_d  = mode_q;
        post_d  = post_q;
        if (clear) begin
            state_d = S_IDLE;
        end else begin
            case (state_q)
                S_IDLE, S_DONE: begin
                    if (start) begin
                        mode_d  = decode_mode(mode);
                        state_d = (decode_mode(mode) == M_TRIGGER) ? S_ARMED : S_CAPTURE;
                    end
                end
                S_ARMED: begin
                    if (stop) begin
                        state_d = S_DONE;
                    end else if (trig_hit) begin
                        post_d  = (post_cnt == '0) ? '0 : post_cnt - CNT_W'(1);
                        state_d = S_CAPTURE;
                    end
                end
                S_CAPTURE: begin
                    if (stop) begin
                        state_d = S_DONE;
                    end else begin
                        case (mode_q)
                            M_STOP_FULL: if (cnt_after == CNT_W'(DEPTH)) state_d = S_DONE;
                            M_TRIGGER: begin
                                if (post_done) begin
                                    state_d = S_DONE;
                                end else if (win_found) begin
                                    post_d = post_q - CNT_W'(1);
                                    if (post_q == CNT_W'(1))
                                        state_d = S_DONE;
                                end
                            end
                            default: ;
                        endcase
                    end
                end
                default: state_d = S_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            mode_q  <= M_STOP_FULL;
            post_q  <= '0;
        end else begin
            state_q <= state_d;
            mode_q  <= mode_d;
            post_q  <= post_d;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ts_q   <= '0;
            drop_q <= '0;
            ovf_q  <= 1'b0;
        end else if (clear) begin
            ts_q   <= '0;
            drop_q <= '0;
            ovf_q  <= 1'b0;
        end else begin
            ts_q   <= ts_q + TS_WIDTH'(1);
            drop_q <= drop_sum[16] ? DROP_SAT : drop_sum[15:0];
            if (drop_inc != '0 || lost_overwrite)
                ovf_q <= 1'b1;
        end
    end

    udlx_trace_fifo #(
        .DEPTH (DEPTH),
        .W     (E_W),
        .CNT_W (CNT_W)
    ) u_fifo (
        .clk            (clk),
        .rst_n          (rst_n),
        .clear          (clear),
        .push           (push),
        .pop            (rd_ready),
        .wrap_overwrite (wrap_mode),
        .wr_data        ({ts_q, sel_idx, sel_addr, sel_data}),
        .count          (count),
        .full           (full),
        .head           (head)
    );

    assign rd_valid = (count != '0);
    assign rd_data  = rd_valid ? head : '0;
    assign overflow = ovf_q;
    assign drop_cnt = drop_q;
    assign state_o  = state_q;

endmodule

// File: tb/tb_udlx_trace_buffer.sv
// Directed bench for udlx_trace_buffer with a queue-based reference model checked every cycle.
module tb_udlx_trace_buffer;
    import udlx_trace_pkg::*;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [2:0]  ch_valid;
    logic [59:0] ch_addr;
    logic [95:0] ch_data;
    logic [1:0]  mode;
    logic        start, stop, clear;
    logic [1:0]  trig_ch;
    logic [19:0] trig_addr;
    logic [6:0]  post_cnt;
    logic        rd_valid, rd_ready;
    logic [69:0] rd_data;
    logic [6:0]  count;
    logic        full, overflow;
    logic [15:0] drop_cnt;
    logic [1:0]  state_o;

    int n_checks = 0;
    int n_errors = 0;
    bit cmp_en   = 1'b0;

    // reference model state
    logic [69:0] q[$];
    int          m_state;
    int          m_mode;
    int          m_post;
    logic [15:0] m_ts;
    int          m_drop;
    bit          m_ovf;

    always #5 clk = ~clk;

    udlx_trace_buffer #(
        .N_CH       (3),
        .ADDR_WIDTH (20),
        .DATA_WIDTH (32),
        .DEPTH      (64),
        .TS_WIDTH   (16)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .ch_valid  (ch_valid),
        .ch_addr   (ch_addr),
        .ch_data   (ch_data),
        .mode      (mode),
        .start     (start),
        .stop      (stop),
        .clear     (clear),
        .trig_ch   (trig_ch),
        .trig_addr (trig_addr),
        .post_cnt  (post_cnt),
        .rd_valid  (rd_valid),
        .rd_ready  (rd_ready),
        .rd_data   (rd_data),
        .count     (count),
        .full      (full),
        .overflow  (overflow),
        .drop_cnt  (drop_cnt),
        .state_o   (state_o)
    );

    task automatic check(input string name, input logic [69:0] act, input logic [69:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic model_reset();
        q.delete();
        m_state = 0; m_mode = 0; m_post = 0;
        m_ts = '0; m_drop = 0; m_ovf = 1'b0;
    endtask

    task automatic add_drop(input int n);
        if (n > 0) begin
            m_ovf  = 1'b1;
            m_drop = (m_drop + n > 65535) ? 65535 : m_drop + n;
        end
    endtask

    // One clock of spec behaviour, using the inputs that were present at the edge.
    task automatic model_step();
        int nv, win, sz;
        bit popped, trig, cap;
        logic [69:0] e;
        logic [19:0] a;
        logic [31:0] d;
        if (!rst_n) return;
        if (clear) begin
            q.delete(); m_ts = '0; m_drop = 0; m_ovf = 1'b0; m_state = 0;
            return;
        end
        sz     = q.size();
        popped = rd_ready && (sz > 0);
        if (popped) void'(q.pop_front());
        nv = 0; win = -1;
        for (int i = 0; i < 3; i++)
            if (ch_valid[i]) begin nv++; if (win < 0) win = i; end
        trig = (m_state == 1) && ch_valid[trig_ch] && (ch_addr[trig_ch*20 +: 20] == trig_addr);
        cap  = ((m_state == 2) && !(m_mode == 2 && m_post == 0)) || trig;
        if (trig) win = int'(trig_ch);
        if (cap && nv > 0) begin
            add_drop(nv - 1);
            a = ch_addr[win*20 +: 20];
            d = ch_data[win*32 +: 32];
            e = {m_ts, 2'(win), a, d};
            if (sz == 64) begin
                if (m_mode == 1) begin
                    if (!popped) begin void'(q.pop_front()); m_ovf = 1'b1; end
                    q.push_back(e);
                end else begin
                    add_drop(1);
                end
            end else begin
                q.push_back(e);
            end
        end
        case (m_state)
            0, 3: if (start) begin
                m_mode  = (mode == 2'd3) ? 0 : int'(mode);
                m_state = (m_mode == 2) ? 1 : 2;
            end
            1: if (stop) m_state = 3;
               else if (trig) begin
                   m_post  = (post_cnt == 0) ? 0 : int'(post_cnt) - 1;
                   m_state = 2;
               end
            2: if (stop) m_state = 3;
               else if (m_mode == 0) begin
                   if (q.size() == 64) m_state = 3;
               end else if (m_mode == 2) begin
                   if (m_post == 0) m_state = 3;
                   else if (nv > 0) begin
                       m_post--;
                       if (m_post == 0) m_state = 3;
                   end
               end
            default: ;
        endcase
        m_ts = m_ts + 16'd1;
    endtask

    always @(negedge clk) begin
        if (cmp_en) begin
            check("state_o",  70'(state_o),  70'(m_state));
            check("count",    70'(count),    70'(q.size()));
            check("rd_valid", 70'(rd_valid), 70'(q.size() != 0));
            check("full",     70'(full),     70'(q.size() == 64));
            check("overflow", 70'(overflow), 70'(m_ovf));
            check("drop_cnt", 70'(drop_cnt), 70'(m_drop));
            check("rd_data",  rd_data, (q.size() != 0) ? q[0] : 70'd0);
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
        model_step();
    endtask

    task automatic set_ch(input int i, input logic [19:0] a);
        ch_addr[i*20 +: 20] = a;
        ch_data[i*32 +: 32] = {4'(i), 8'h5A, a};
    endtask

    task automatic ev(input logic [2:0] v, input logic [19:0] a);
        for (int i = 0; i < 3; i++) set_ch(i, a + 20'(i * 16'h1000));
        ch_valid = v;
        tick();
        ch_valid = '0;
    endtask

    task automatic do_start(input logic [1:0] m);
        mode = m; start = 1'b1; tick(); start = 1'b0;
    endtask

    task automatic do_stop();
        stop = 1'b1; tick(); stop = 1'b0;
    endtask

    task automatic do_clear();
        clear = 1'b1; tick(); clear = 1'b0;
    endtask

    // Pop n entries and compare each against an address sequence and the expected channel.
    task automatic drain(input string name, input int n, input logic [19:0] base, input int step,
                         input logic [1:0] ch);
        trace_entry_t e;
        logic [15:0]  prev;
        for (int k = 0; k < n; k++) begin
            e = rd_data;
            check({name, "_addr"}, 70'(e.addr), 70'(base + 20'(k * step)));
            check({name, "_ch"}, 70'(e.ch), 70'(ch));
            if (k > 0) check({name, "_ts_order"}, 70'(e.ts > prev), 70'd1);
            prev = e.ts;
            rd_ready = 1'b1; tick(); rd_ready = 1'b0;
        end
    endtask

    initial begin
        trace_entry_t e;
        rst_n = 1'b0; ch_valid = '0; ch_addr = '0; ch_data = '0; mode = '0;
        start = 1'b0; stop = 1'b0; clear = 1'b0; trig_ch = '0; trig_addr = '0;
        post_cnt = '0; rd_ready = 1'b0;
        model_reset();
        #3;
        check("rst_state", 70'(state_o), 70'd0);
        check("rst_count", 70'(count), 70'd0);
        check("rst_valid", 70'(rd_valid), 70'd0);
        check("rst_data", rd_data, 70'd0);
        check("rst_drop", 70'(drop_cnt), 70'd0);
        tick(); tick();
        rst_n = 1'b1;
        cmp_en = 1'b1;

        // STOP_FULL: 70 ch1 events, first 64 kept
        do_start(2'd0);
        for (int i = 0; i < 70; i++) ev(3'b010, 20'(i) - 20'h1000);
        check("sf_state", 70'(state_o), 70'd3);
        check("sf_count", 70'(count), 70'd64);
        check("sf_drop", 70'(drop_cnt), 70'd0);
        drain("sf", 64, 20'h0, 1, 2'd1);
        check("sf_empty", 70'(count), 70'd0);

        // WRAP: 70 ch0 events, last 64 kept
        do_clear();
        do_start(2'd1);
        for (int i = 0; i < 70; i++) ev(3'b001, 20'(i));
        do_stop();
        check("wr_ovf", 70'(overflow), 70'd1);
        check("wr_count", 70'(count), 70'd64);
        drain("wr", 64, 20'd6, 1, 2'd0);
        check("wr_empty", 70'(count), 70'd0);

        // TRIGGER on ch2 @0x00100, post_cnt=4
        do_clear();
        trig_ch = 2'd2; trig_addr = 20'h00100; post_cnt = 7'd4;
        do_start(2'd2);
        check("tg_armed", 70'(state_o), 70'd1);
        ev(3'b100, 20'h000F0 - 20'h2000);
        ev(3'b100, 20'h00100 - 20'h2000);
        ev(3'b100, 20'h00104 - 20'h2000);
        ev(3'b100, 20'h00108 - 20'h2000);
        ev(3'b100, 20'h0010C - 20'h2000);
        ev(3'b100, 20'h00110 - 20'h2000);
        check("tg_state", 70'(state_o), 70'd3);
        check("tg_count", 70'(count), 70'd4);
        drain("tg", 4, 20'h00100, 4, 2'd2);

        // all channels together: ch0 wins, two drops per cycle
        do_clear();
        do_start(2'd0);
        for (int i = 0; i < 5; i++) ev(3'b111, 20'h00400 + 20'(i));
        check("ar_count", 70'(count), 70'd5);
        check("ar_drop", 70'(drop_cnt), 70'd10);
        check("ar_ovf", 70'(overflow), 70'd1);
        drain("ar", 5, 20'h00400, 1, 2'd0);

        // WRAP full with simultaneous push and pop
        do_clear();
        do_start(2'd1);
        for (int i = 0; i < 64; i++) ev(3'b001, 20'h00200 + 20'(i));
        check("wp_full", 70'(full), 70'd1);
        e = rd_data;
        check("wp_oldest", 70'(e.addr), 70'h00200);
        rd_ready = 1'b1;
        ev(3'b001, 20'h00300);
        rd_ready = 1'b0;
        check("wp_count", 70'(count), 70'd64);
        do_stop();
        drain("wp", 63, 20'h00201, 1, 2'd0);
        e = rd_data;
        check("wp_tail", 70'(e.addr), 70'h00300);
        rd_ready = 1'b1; tick(); rd_ready = 1'b0;

        // clear beats start while capturing; timestamp restarts
        do_clear();
        do_start(2'd0);
        for (int i = 0; i < 10; i++) ev(3'b011, 20'h00500 + 20'(i));
        check("cl_pre_count", 70'(count), 70'd10);
        clear = 1'b1; start = 1'b1; tick(); clear = 1'b0; start = 1'b0;
        check("cl_state", 70'(state_o), 70'd0);
        check("cl_count", 70'(count), 70'd0);
        check("cl_valid", 70'(rd_valid), 70'd0);
        check("cl_drop", 70'(drop_cnt), 70'd0);
        do_start(2'd0);
        ev(3'b001, 20'h00600);
        e = rd_data;
        check("cl_ts", 70'(e.ts), 70'd1);

        // asynchronous reset in the middle of a capture
        for (int i = 0; i < 3; i++) ev(3'b110, 20'h00700 + 20'(i));
        @(posedge clk);
        #3;
        rst_n = 1'b0;
        #1;
        model_reset();
        check("ar_rst_state", 70'(state_o), 70'd0);
        check("ar_rst_count", 70'(count), 70'd0);
        check("ar_rst_valid", 70'(rd_valid), 70'd0);
        check("ar_rst_data", rd_data, 70'd0);
        check("ar_rst_drop", 70'(drop_cnt), 70'd0);
        check("ar_rst_ovf", 70'(overflow), 70'd0);
        tick();
        rst_n = 1'b1;
        tick(); tick();

        cmp_en = 1'b0;
        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
